// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch front end with a 4-entry prefetch FIFO, credit-based issue,
// redirect discard tracking and halt. Define IFETCH_BYPASS_EN for same-cycle response bypass.
module ifetch_buf #(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_re,
  output logic [15:0] im_addr,
  input  logic [16:0] im_rdata,
  input  logic        im_rvld,
  output logic [16:0] instr,
  output logic        instr_vld,
  output logic [15:0] instr_pc,
  input  logic        stall,
  input  logic        flow_change,
  input  logic [15:0] dst_pc,
  input  logic        hlt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic [15:0] pc_r;
  logic [15:0] rsp_pc_r;
  logic [32:0] fifo_r [0:3];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  count_r;
  logic [2:0]  outs_r;
  logic [2:0]  drop_r;
  logic [2:0]  count_nxt_s;
  logic [2:0]  outs_nxt_s;
  logic [2:0]  drop_nxt_s;
  logic        fifo_empty_s;
  logic        credit_s;
  logic        issue_s;
  logic        drop_beat_s;
  logic        keep_beat_s;
  logic        bypass_s;
  logic        push_s;
  logic        pop_s;

  // Issue credit, response classification and FIFO push/pop qualification
  always_comb begin
    fifo_empty_s = (count_r == 3'd0);
    credit_s     = (({1'b0, count_r} + {1'b0, outs_r}) < 4'd4);
    issue_s      = !rst && (state_r == ST_RUN) && !flow_change && credit_s;
    drop_beat_s  = im_rvld && (drop_r != 3'd0);
    keep_beat_s  = im_rvld && (drop_r == 3'd0);
`ifdef IFETCH_BYPASS_EN
    bypass_s     = !rst && fifo_empty_s && keep_beat_s && !stall && !flow_change;
`else
    bypass_s     = 1'b0;
`endif
    push_s       = keep_beat_s && !flow_change && !bypass_s;
    pop_s        = !fifo_empty_s && !stall && !flow_change;
  end

  // Next values of the occupancy, outstanding and discard counters
  always_comb begin
    count_nxt_s = count_r;
    outs_nxt_s  = outs_r;
    drop_nxt_s  = drop_r;
    if (flow_change) begin
      // every request still in flight becomes a beat to throw away
      count_nxt_s = 3'd0;
      outs_nxt_s  = 3'd0;
      drop_nxt_s  = drop_r + outs_r - {2'b00, im_rvld};
    end else begin
      count_nxt_s = count_r + {2'b00, push_s} - {2'b00, pop_s};
      outs_nxt_s  = outs_r + {2'b00, issue_s} - {2'b00, keep_beat_s};
      drop_nxt_s  = drop_r - {2'b00, drop_beat_s};
    end
  end

  // Run/halt state transition; a redirect wins over a simultaneous halt
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (hlt && !flow_change) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Memory request and decoder-facing instruction outputs
  always_comb begin
    im_re     = issue_s;
    im_addr   = pc_r;
    instr     = 17'h00000;
    instr_vld = 1'b0;
    instr_pc  = 16'h0000;
    if (rst) begin
      instr_vld = 1'b0;
    end else if (bypass_s) begin
      instr     = im_rdata;
      instr_vld = 1'b1;
      instr_pc  = rsp_pc_r;
    end else if (!fifo_empty_s) begin
      {instr_pc, instr} = fifo_r[rd_ptr_r];
      instr_vld         = 1'b1;
    end else begin
      instr_vld = 1'b0;
    end
  end

  // Control state, fetch/response PCs, FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      pc_r     <= RST_PC;
      rsp_pc_r <= RST_PC;
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      outs_r   <= 3'd0;
      drop_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      outs_r  <= outs_nxt_s;
      drop_r  <= drop_nxt_s;
      if (flow_change) begin
        pc_r     <= dst_pc;
        rsp_pc_r <= dst_pc;
        wr_ptr_r <= 2'd0;
        rd_ptr_r <= 2'd0;
      end else begin
        if (issue_s) pc_r <= pc_r + 16'd1;
        if (keep_beat_s) rsp_pc_r <= rsp_pc_r + 16'd1;
        if (push_s) wr_ptr_r <= wr_ptr_r + 2'd1;
        if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      end
    end
  end

  // FIFO payload storage; entries are only read while counted as occupied
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_r[wr_ptr_r] <= {rsp_pc_r, im_rdata};
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf with a latency-configurable in-order instruction memory model.
module tb_ifetch_buf;

`ifdef IFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        im_re;
  logic [15:0] im_addr;
  logic [16:0] im_rdata;
  logic        im_rvld;
  logic [16:0] instr;
  logic        instr_vld;
  logic [15:0] instr_pc;
  logic        stall;
  logic        flow_change;
  logic [15:0] dst_pc;
  logic        hlt;

  int          lat;
  int          n_vec;
  int          n_err;
  int          got;
  logic [15:0] exp_pc;
  logic        mv [0:2];
  logic [15:0] ma [0:2];

  ifetch_buf #(.RST_PC(16'h0010)) dut (
    .clk        (clk),
    .rst        (rst),
    .im_re      (im_re),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .im_rvld    (im_rvld),
    .instr      (instr),
    .instr_vld  (instr_vld),
    .instr_pc   (instr_pc),
    .stall      (stall),
    .flow_change(flow_change),
    .dst_pc     (dst_pc),
    .hlt        (hlt)
  );

  function automatic logic [16:0] mem_word(input logic [15:0] a);
    return {a[3], a ^ 16'h3C5A};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory request pipeline, reset together with the DUT
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] <= 1'b0;
        ma[k] <= 16'h0000;
      end
    end else begin
      mv[0] <= im_re;
      ma[0] <= im_addr;
      mv[1] <= mv[0];
      ma[1] <= ma[0];
      mv[2] <= mv[1];
      ma[2] <= ma[1];
    end
  end

  always_comb begin
    im_rvld  = mv[0];
    im_rdata = mem_word(ma[0]);
    if (lat == 2) begin
      im_rvld  = mv[1];
      im_rdata = mem_word(ma[1]);
    end else if (lat == 3) begin
      im_rvld  = mv[2];
      im_rdata = mem_word(ma[2]);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic score();
    if (instr_vld) begin
      chk("seq_pc", 33'(instr_pc), 33'(exp_pc));
      chk("seq_instr", 33'(instr), 33'(mem_word(exp_pc)));
      exp_pc = exp_pc + 16'd1;
      got++;
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    stall = 1'b0;
    flow_change = 1'b0;
    hlt = 1'b0;
    smp();
    chk("rst_im_re", 33'(im_re), 33'd0);
    chk("rst_instr", 33'(instr), 33'd0);
    chk("rst_vld", 33'(instr_vld), 33'd0);
    chk("rst_pc", 33'(instr_pc), 33'd0);
    nxt();
    lat = l;
    nxt();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] dst, input logic h, input int ncyc,
                          input int nquiet, input int expn);
    logic [15:0] a;
    flow_change = 1'b1;
    dst_pc = dst;
    hlt = h;
    smp();
    chk("fc_im_re", 33'(im_re), 33'd0);
    nxt();
    flow_change = 1'b0;
    hlt = 1'b0;
    exp_pc = dst;
    got = 0;
    for (int i = 0; i < ncyc; i++) begin
      smp();
      a = dst + 16'(i);
      chk("rd_im_re", 33'(im_re), 33'd1);
      chk("rd_addr", 33'(im_addr), 33'(a));
      if (i < nquiet) chk("rd_quiet", 33'(instr_vld), 33'd0);
      score();
      nxt();
    end
    chk("rd_count", 33'(got), 33'(expn));
  endtask

  initial begin
    logic [15:0] p;
    n_vec = 0;
    n_err = 0;
    got = 0;
    exp_pc = 16'h0000;
    lat = 1;
    rst = 1'b1;
    stall = 1'b0;
    flow_change = 1'b0;
    dst_pc = 16'h0000;
    hlt = 1'b0;
    nxt();

    // reset release, free-running 1-cycle memory
    do_reset(1);
    smp();
    chk("c0_re", 33'(im_re), 33'd1);
    chk("c0_addr", 33'(im_addr), 33'h10);
    chk("c0_vld", 33'(instr_vld), 33'd0);
    nxt();
    smp();
    chk("c1_addr", 33'(im_addr), 33'h11);
    chk("c1_vld", 33'(instr_vld), 33'(BYP));
    nxt();
    smp();
    p = (BYP == 1) ? 16'h0011 : 16'h0010;
    chk("c2_addr", 33'(im_addr), 33'h12);
    chk("c2_vld", 33'(instr_vld), 33'd1);
    chk("c2_pc", 33'(instr_pc), 33'(p));
    chk("c2_instr", 33'(instr), 33'(mem_word(p)));
    nxt();

    // stall for 6 cycles from the first cycle after reset, then release
    do_reset(1);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("stall_re", 33'(im_re), 33'(i < 4));
      if (i < 4) chk("stall_addr", 33'(im_addr), 33'(16'h0010 + 16'(i)));
      if (i == 5) begin
        chk("stall_vld", 33'(instr_vld), 33'd1);
        chk("stall_pc", 33'(instr_pc), 33'h10);
        chk("stall_instr", 33'(instr), 33'(mem_word(16'h0010)));
      end
      nxt();
    end
    stall = 1'b0;
    exp_pc = 16'h0010;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      score();
      nxt();
    end
    chk("stall_count", 33'(got), 33'd10);

    // 2-cycle memory: redirect with two requests outstanding, then wrap
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      nxt();
    end
    redirect(16'h0200, 1'b0, 10, 2, 7 + BYP);
    redirect(16'hFFFE, 1'b0, 8, 2, 5 + BYP);

    // redirect and halt together: redirect wins, fetch keeps running
    do_reset(1);
    nxt();
    nxt();
    redirect(16'h0040, 1'b1, 8, 1, 6 + BYP);

    // halt with three requests in flight on a 3-cycle memory
    do_reset(3);
    smp();
    chk("h0_addr", 33'(im_addr), 33'h10);
    nxt();
    smp();
    chk("h1_addr", 33'(im_addr), 33'h11);
    nxt();
    hlt = 1'b1;
    smp();
    chk("h2_re", 33'(im_re), 33'd1);
    chk("h2_addr", 33'(im_addr), 33'h12);
    nxt();
    hlt = 1'b0;
    exp_pc = 16'h0010;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      smp();
      chk("halt_re", 33'(im_re), 33'd0);
      score();
      nxt();
    end
    chk("halt_count", 33'(got), 33'd3);
    smp();
    chk("halt_instr", 33'(instr), 33'd0);
    chk("halt_vld", 33'(instr_vld), 33'd0);
    chk("halt_pc", 33'(instr_pc), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
